// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active low.
package disp_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic {BLANK, ACTIVE} scan_state_t;

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to active-low seven-segment decode; codes 10-15 are blank.
module seg7_bcd_decode
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit seven-segment scan scheduler: per-slot anti-ghost blanking, 16-level PWM
// brightness and a valid/ready double buffer swapped only at frame boundaries.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 250000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  brightness,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       dsel;
  logic [3:0]       pwm_cnt, bright_lat;
  logic             pending, accept, slot_end, frame_end;
  logic [15:0]      shadow, active;
  logic [3:0]       shadow_dp, active_dp;
  logic [3:0]       bcd;
  logic [6:0]       glyph;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_end  = slot_end && (dsel == 2'd3);
  assign load_ready = rst_n && !pending;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:  if (slot_cnt == BLANK_LAST) state_nxt = ACTIVE;
      ACTIVE: if (slot_end)               state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      dsel       <= '0;
      pwm_cnt    <= '0;
      bright_lat <= '0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) dsel <= dsel + 1'b1;
      // Brightness is captured once per slot so a change never alters the current digit.
      if (slot_cnt == '0) bright_lat <= brightness;
      pwm_cnt <= (state == BLANK && state_nxt == ACTIVE) ? '0 : pwm_cnt + 1'b1;
    end
  end

  // The swap keys off the registered frame_done, so pending must predate that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      shadow    <= '1;
      shadow_dp <= '0;
      active    <= '1;
      active_dp <= '0;
    end else begin
      if (accept) begin
        shadow    <= load_data;
        shadow_dp <= load_dp;
        pending   <= 1'b1;
      end else if (frame_done && pending) begin
        active    <= shadow;
        active_dp <= shadow_dp;
        pending   <= 1'b0;
      end
    end
  end

  always_comb begin
    case (dsel)
      2'd0:    bcd = active[3:0];
      2'd1:    bcd = active[7:4];
      2'd2:    bcd = active[11:8];
      default: bcd = active[15:12];
    endcase
  end

  seg7_bcd_decode u_dec (
    .bcd (bcd),
    .seg (glyph)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state == ACTIVE) begin
      seg_d = glyph;
      dp_d  = ~active_dp[dsel];
      if (pwm_cnt <= bright_lat) an_d = ~(4'b0001 << dsel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      digit_sel  <= dsel;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIGIT_TICKS=8, BLANK_TICKS=2 (32-cycle frame).
// After tick t (t posedges since reset release) the outputs show scan cycle t-1.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int n_off, n_lit, n_fd, n_on;

  disp_scan_ctrl #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0; brightness = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_dsel", digit_sel, 2'd0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", load_ready, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", load_ready, 1'b1);
    t = 0;

    // Frame 0: blank buffer, load 1234 at cycle 3, then hold 5678 valid.
    n_off = 0; n_lit = 0; n_fd = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1) begin
        chk("f0_an_blank", an, 4'hF);
        chk("f0_dsel", digit_sel, 2'd0);
      end
      if (k == 2) begin
        load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0001;
      end
      if (k == 3) begin
        chk("f0_an_active", an, 4'b1110);
        chk("ready_low", load_ready, 1'b0);
        load_data = 16'h5678; load_dp = 4'b0000;
      end
      if (an == 4'hF) n_off++;
      if (seg != 7'h7F) n_lit++;
      if (frame_done) n_fd++;
    end
    chk("f0_fd_last", frame_done, 1'b1);
    chk("f0_dsel_last", digit_sel, 2'd3);
    chk("f0_an_last", an, 4'b0111);
    chk("f0_blank_cycles", n_off, 8);
    chk("f0_seg_dark", n_lit, 0);
    chk("f0_fd_count", n_fd, 1);

    tick(); // t=33
    chk("f1_fd_clear", frame_done, 1'b0);
    chk("f1_dsel0", digit_sel, 2'd0);
    chk("ready_after_swap", load_ready, 1'b1);
    tick(); // t=34, 5678 accepted at this edge
    chk("bp_accept", load_ready, 1'b0);
    load_valid = 1'b0;

    n_on = 0;
    for (int k = 35; k <= 40; k++) begin
      tick();
      if (an == 4'b1110 && seg == 7'h19 && dp == 1'b0) n_on++;
    end
    chk("f1_d0_cycles", n_on, 6);
    tick(); // t=41
    chk("f1_d1_blank", an, 4'hF);
    run_to(43);
    chk("f1_d1_seg", seg, 7'h30);
    chk("f1_d1_an", an, 4'b1101);
    chk("f1_d1_dp", dp, 1'b1);
    run_to(51);
    chk("f1_d2_seg", seg, 7'h24);
    run_to(59);
    chk("f1_d3_seg", seg, 7'h79);
    chk("f1_d3_an", an, 4'b0111);
    run_to(64);
    chk("f1_fd", frame_done, 1'b1);
    run_to(67);
    chk("f2_d0_seg", seg, 7'h00);
    chk("f2_d0_dp", dp, 1'b1);
    run_to(75);
    chk("f2_d1_seg", seg, 7'h78);

    // Brightness: 0 for slot at c=96, 3 for c=104, 15 for c=112; mid-slot changes.
    run_to(90);
    brightness = 4'd0;
    run_to(96);
    n_on = 0;
    for (int k = 97; k <= 104; k++) begin
      tick();
      if (an != 4'hF) n_on++;
      if (k == 100) brightness = 4'd3;
    end
    chk("bright0_cycles", n_on, 1);
    n_on = 0;
    for (int k = 105; k <= 112; k++) begin
      tick();
      if (an != 4'hF) n_on++;
      if (k == 107) brightness = 4'd15;
    end
    chk("bright3_cycles", n_on, 4);
    n_on = 0;
    for (int k = 113; k <= 120; k++) begin
      tick();
      if (an != 4'hF) n_on++;
    end
    chk("bright15_cycles", n_on, 6);

    // FA09: 9, 0, blank, blank.
    load_valid = 1'b1; load_data = 16'hFA09; load_dp = 4'b0000;
    tick(); // t=121
    load_valid = 1'b0;
    chk("fa09_accept", load_ready, 1'b0);
    run_to(131);
    chk("fa09_d0", seg, 7'h10);
    chk("fa09_d0_an", an, 4'b1110);
    run_to(139);
    chk("fa09_d1", seg, 7'h40);
    run_to(147);
    chk("fa09_d2", seg, 7'h7F);
    chk("fa09_d2_an", an, 4'b1011);
    run_to(155);
    chk("fa09_d3", seg, 7'h7F);

    // Reset in slot 2 with 8888 pending.
    run_to(160);
    load_valid = 1'b1; load_data = 16'h8888; load_dp = 4'hF;
    tick(); // t=161
    load_valid = 1'b0;
    chk("pend_8888", load_ready, 1'b0);
    run_to(180);
    chk("pre_rst_dsel", digit_sel, 2'd2);
    chk("pre_rst_an", an, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_dsel", digit_sel, 2'd0);
    chk("async_ready", load_ready, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rel_ready", load_ready, 1'b1);
    t = 0;
    tick();
    chk("rel_dsel", digit_sel, 2'd0);
    chk("rel_an", an, 4'hF);
    run_to(3);
    chk("rel_an_active", an, 4'b1110);
    chk("rel_seg_blank", seg, 7'h7F);
    run_to(32);
    chk("rel_fd", frame_done, 1'b1);
    run_to(35);
    chk("rel_no_8888", seg, 7'h7F);
    chk("rel_ready_end", load_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
